// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the M-extension sequencer: funct3 encodings, ALU op codes,
// opcode constants, the sequencer FSM state type and small funct3 decode helpers.
package rv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [3:0] ALU_MUL = 4'hA;
  localparam logic [3:0] ALU_DIV = 4'hB;
  localparam logic [3:0] ALU_REM = 4'hC;

  localparam logic [6:0] OP_REG = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic md_is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  function automatic logic md_signed_a(input logic [2:0] f3);
    return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_MULHSU) ||
           (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic md_signed_b(input logic [2:0] f3);
    return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: shift-add multiply or restoring divide on operand magnitudes,
// followed by a sign-correcting fix step that writes the held result register.
module muldiv_iter_dp
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_fix,
  input  logic            i_special,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_special_val,
  output logic [XLEN-1:0] o_result
);

  logic [2:0]      r_op;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_res;

  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_add;
  logic [XLEN:0]     w_madd;
  logic [XLEN:0]     w_shl;
  logic [XLEN:0]     w_sub;
  logic              w_ge;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_sa    = md_signed_a(i_funct3) && i_a[XLEN-1];
  assign w_sb    = md_signed_b(i_funct3) && i_b[XLEN-1];
  assign w_mag_a = w_sa ? (~i_a + 1'b1) : i_a;
  assign w_mag_b = w_sb ? (~i_b + 1'b1) : i_b;

  // Multiply: r_lo holds the multiplier and shifts right into the low product half.
  assign w_add  = {1'b0, r_hi} + {1'b0, r_b};
  assign w_madd = r_lo[0] ? w_add : {1'b0, r_hi};

  // Divide: partial remainder stays below the divisor, so the sign of w_sub decides.
  assign w_shl = {r_hi, r_lo[XLEN-1]};
  assign w_sub = w_shl - {1'b0, r_b};
  assign w_ge  = !w_sub[XLEN];

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo    = r_neg_q ? (~r_lo + 1'b1) : r_lo;
  assign w_rem    = r_neg_r ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    w_fix_res = '0;
    unique case (r_op)
      MD_MUL:                       w_fix_res = w_prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_fix_res = w_quo;
      MD_REM, MD_REMU:              w_fix_res = w_rem;
      default:                      w_fix_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_res   <= '0;
    end else begin
      if (i_load) begin
        r_op    <= i_funct3;
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_hi    <= '0;
        if (md_is_div(i_funct3)) begin
          r_b  <= w_mag_b;
          r_lo <= w_mag_a;
        end else begin
          r_b  <= w_mag_a;
          r_lo <= w_mag_b;
        end
      end else if (i_step) begin
        if (md_is_div(r_op)) begin
          r_hi <= w_ge ? w_sub[XLEN-1:0] : w_shl[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], w_ge};
        end else begin
          r_hi <= w_madd[XLEN:1];
          r_lo <= {w_madd[0], r_lo[XLEN-1:1]};
        end
      end

      if (i_fix) begin
        r_res <= w_fix_res;
      end else if (i_special) begin
        r_res <= i_special_val;
      end
    end
  end

  assign o_result = r_res;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: handshake, FSM, iteration counter and divide special cases;
// arithmetic is delegated to muldiv_iter_dp.
module muldiv_sequencer
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_resp_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CntW = $clog2(XLEN);

  md_state_e       r_state;
  md_state_e       w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;

  logic            w_accept;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_val;
  logic            w_load;
  logic            w_step;
  logic            w_fix;
  logic            w_load_special;

  assign w_accept   = i_req_valid && (r_state == IDLE) && !i_flush;
  assign w_div_zero = md_is_div(i_funct3) && (i_rs2_val == '0);
  assign w_div_ovf  = ((i_funct3 == MD_DIV) || (i_funct3 == MD_REM)) &&
                      (i_rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_val == '1);
  assign w_special  = w_div_zero || w_div_ovf;

  always_comb begin
    w_special_val = '0;
    if (w_div_zero) begin
      w_special_val = md_is_rem(i_funct3) ? i_rs1_val : '1;
    end else if (w_div_ovf) begin
      w_special_val = md_is_rem(i_funct3) ? '0 : i_rs1_val;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_special) begin
            w_state_next = DONE;
          end else begin
            w_state_next = CALC;
            w_cnt_next   = CntW'(XLEN - 1);
          end
        end
      end
      CALC: begin
        if (i_flush) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == '0) begin
          w_state_next = FIX;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      FIX:     w_state_next = i_flush ? IDLE : DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_load         = w_accept && !w_special;
  assign w_load_special = w_accept && w_special;
  assign w_step         = (r_state == CALC) && !i_flush;
  assign w_fix          = (r_state == FIX) && !i_flush;

  assign o_req_ready  = (r_state == IDLE);
  assign o_busy       = (r_state != IDLE);
  assign o_resp_valid = (r_state == DONE) && !i_flush;

  muldiv_iter_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_fix        (w_fix),
    .i_special    (w_load_special),
    .i_funct3     (i_funct3),
    .i_a          (i_rs1_val),
    .i_b          (i_rs2_val),
    .i_special_val(w_special_val),
    .o_result     (o_result)
  );

endmodule
